// File: rtl/lcd_host_pkg.sv
// Shared command codes, FSM state encoding and helpers for the LCD host issuer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package lcd_host_pkg;

    // Command code width on the controller interface
    localparam int CMD_W = 4;

    // Legal command codes understood by the LCD controller
    localparam logic [CMD_W-1:0] CMD_WRITE    = 4'd0;
    localparam logic [CMD_W-1:0] CMD_SHIFT_L  = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SHIFT_R  = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHIFT_U  = 4'd3;
    localparam logic [CMD_W-1:0] CMD_SHIFT_D  = 4'd4;
    localparam logic [CMD_W-1:0] CMD_MAX      = 4'd5;
    localparam logic [CMD_W-1:0] CMD_MIN      = 4'd6;
    localparam logic [CMD_W-1:0] CMD_AVG      = 4'd7;
    localparam logic [CMD_W-1:0] CMD_ROT_CW   = 4'd8;
    localparam logic [CMD_W-1:0] CMD_ROT_CCW  = 4'd9;
    localparam logic [CMD_W-1:0] CMD_MIRROR_X = 4'd10;
    localparam logic [CMD_W-1:0] CMD_MIRROR_Y = 4'd11;

    // Codes at or above this value are not understood by the controller
    localparam logic [CMD_W-1:0] CMD_ILLEGAL_MIN = 4'd12;

    // One-hot FSM: bit indices and state constants
    localparam int STATE_W      = 4;
    localparam int ST_IDLE      = 0;
    localparam int ST_HOLD      = 1;
    localparam int ST_WAIT_DONE = 2;
    localparam int ST_END       = 3;

    localparam logic [STATE_W-1:0] S_IDLE      = 4'b0001;
    localparam logic [STATE_W-1:0] S_HOLD      = 4'b0010;
    localparam logic [STATE_W-1:0] S_WAIT_DONE = 4'b0100;
    localparam logic [STATE_W-1:0] S_END       = 4'b1000;

    // True when the controller will accept this code
    function automatic logic is_legal_cmd(input logic [CMD_W-1:0] code);
        return (code < CMD_ILLEGAL_MIN);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO holding pending command codes, head exposed combinationally.
// Latency: an entry written at edge t is visible on pop_data/empty after edge t.
// Backpressure: full is registered; pushes while full and pops while empty are ignored.
module lcd_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow regardless of what the caller does
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (level == LVL_FULL);
    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level spans 0..DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// Buffers host commands and issues them one per controller idle window, halting after WRITE completes.
// Latency: command pushed at edge t strobes cmd_valid after edge t+1 when busy is low; strobes spaced HOLDOFF+2 cycles.
// Backpressure: push_ready drops when the FIFO is full (registered) or the session has ended.
module lcd_cmd_issuer
    import lcd_host_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int HOLDOFF = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [CMD_W-1:0] push_cmd,
    output logic             push_ready,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    input  logic             busy,
    input  logic             done,
    output logic [CNT_W-1:0] issued_cnt,
    output logic             illegal_cmd,
    output logic             session_done
);

    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               hold_last;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CMD_W-1:0]   fifo_head;
    logic               head_legal;
    logic               issue;
    logic               drop;

    // Upstream handshake: the ended session stops accepting anything
    assign push_ready = !fifo_full && !state[ST_END];
    assign fifo_push  = push_valid && push_ready;

    // Pop only while idle, controller not busy, and something is queued
    assign fifo_pop   = state[ST_IDLE] && !fifo_empty && !busy;
    assign head_legal = is_legal_cmd(fifo_head);
    assign issue      = fifo_pop && head_legal;
    assign drop       = fifo_pop && !head_legal;
    assign hold_last  = (hold_cnt == '0);

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state logic; busy is not looked at in S_HOLD because the controller's busy lags the strobe
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_last) begin
                    state_nxt = (cmd == CMD_WRITE) ? S_WAIT_DONE : S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (done) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                state_nxt = S_END;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold-off counter: loaded on issue, counts down through S_HOLD (1+HOLDOFF cycles)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (issue) begin
            hold_cnt <= HOLD_LOAD;
        end else if (state[ST_HOLD] && !hold_last) begin
            hold_cnt <= hold_cnt - HOLD_ONE;
        end
    end

    // Command bus and one-cycle strobe; cmd keeps the last issued code
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd       <= '0;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= issue;
            if (issue) begin
                cmd <= fifo_head;
            end
        end
    end

    // Issued-command counter, saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_cnt <= '0;
        end else if (issue && (issued_cnt != '1)) begin
            issued_cnt <= issued_cnt + CNT_ONE;
        end
    end

    // Sticky status flags: dropped illegal code, and session completion on entry to S_END
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_cmd  <= 1'b0;
            session_done <= 1'b0;
        end else begin
            if (drop) begin
                illegal_cmd <= 1'b1;
            end
            if (state[ST_WAIT_DONE] && done) begin
                session_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
`timescale 1ns/1ps
module tb_lcd_cmd_issuer;

    localparam int DEPTH   = 16;
    localparam int HOLDOFF = 2;
    localparam int CNT_W   = 8;
    localparam int GAP     = HOLDOFF + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             push_valid;
    logic [3:0]       push_cmd;
    logic             push_ready;
    logic [3:0]       cmd;
    logic             cmd_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] issued_cnt;
    logic             illegal_cmd;
    logic             session_done;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int exp_cnt    = 0;

    logic [3:0] strobe_q[$];
    int         strobe_t[$];

    lcd_cmd_issuer #(
        .DEPTH   (DEPTH),
        .HOLDOFF (HOLDOFF),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push_valid   (push_valid),
        .push_cmd     (push_cmd),
        .push_ready   (push_ready),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .busy         (busy),
        .done         (done),
        .issued_cnt   (issued_cnt),
        .illegal_cmd  (illegal_cmd),
        .session_done (session_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the cycle number of the edge that raised it
    always @(negedge clk) begin
        if (reset === 1'b1 && cmd_valid === 1'b1) begin
            strobe_q.push_back(cmd);
            strobe_t.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 300000ns");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        strobe_q.delete();
        strobe_t.delete();
    endtask

    // Offer one code for up to budget cycles; reports acceptance and the accepting edge
    task automatic push_code(input logic [3:0] c, input int budget, output bit ok, output int t_acc);
        push_valid = 1'b1;
        push_cmd   = c;
        ok         = 1'b0;
        t_acc      = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = push_ready;
            tick();
            if (ok) t_acc = cyc;
        end
        push_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        vectors++; if (cmd !== 4'd0) begin miscompares++; $display("FAIL rst_cmd: got %0d want 0", cmd); end
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
        vectors++; if (issued_cnt !== '0) begin miscompares++; $display("FAIL rst_issued_cnt: got %0d want 0", issued_cnt); end
        vectors++; if (illegal_cmd !== 1'b0) begin miscompares++; $display("FAIL rst_illegal: got %b want 0", illegal_cmd); end
        vectors++; if (session_done !== 1'b0) begin miscompares++; $display("FAIL rst_session_done: got %b want 0", session_done); end
        vectors++; if (push_ready !== 1'b1) begin miscompares++; $display("FAIL rst_push_ready: got %b want 1", push_ready); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_busy_hold();
        logic [3:0] codes[3];
        bit ok;
        int t, c0;
        codes[0] = 4'd1; codes[1] = 4'd2; codes[2] = 4'd3;
        busy = 1'b1;
        clear_log();
        for (int i = 0; i < 3; i++) begin
            push_code(codes[i], 2, ok, t);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL busy_push_%0d: accepted %b want 1", i, ok); end
        end
        wait_cycles(6);
        @(negedge clk);
        vectors++; if (strobe_q.size() != 0) begin miscompares++; $display("FAIL busy_no_strobe: got %0d strobes want 0", strobe_q.size()); end
        vectors++; if (push_ready !== 1'b1) begin miscompares++; $display("FAIL busy_push_ready: got %b want 1", push_ready); end
        vectors++; if (issued_cnt !== CNT_W'(exp_cnt)) begin miscompares++; $display("FAIL busy_cnt: got %0d want %0d", issued_cnt, exp_cnt); end
        tick();
        busy = 1'b0;
        c0 = cyc;
        wait_cycles(16);
        vectors++; if (strobe_q.size() != 3) begin miscompares++; $display("FAIL release_count: got %0d want 3", strobe_q.size()); end
        for (int i = 0; i < 3 && i < strobe_q.size(); i++) begin
            int want_t;
            want_t = c0 + 1 + i * GAP;
            vectors++; if (strobe_q[i] !== codes[i]) begin miscompares++; $display("FAIL release_code_%0d: got %0d want %0d", i, strobe_q[i], codes[i]); end
            vectors++; if (strobe_t[i] != want_t) begin miscompares++; $display("FAIL release_time_%0d: got %0d want %0d", i, strobe_t[i], want_t); end
        end
        exp_cnt += 3;
        vectors++; if (issued_cnt !== CNT_W'(exp_cnt)) begin miscompares++; $display("FAIL release_cnt: got %0d want %0d", issued_cnt, exp_cnt); end
    endtask

    task automatic test_single_latency();
        bit ok;
        int t;
        busy = 1'b0;
        clear_log();
        push_code(4'd4, 2, ok, t);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_push: accepted %b want 1", ok); end
        wait_cycles(8);
        vectors++; if (strobe_q.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", strobe_q.size()); end
        if (strobe_q.size() > 0) begin
            vectors++; if (strobe_q[0] !== 4'd4) begin miscompares++; $display("FAIL single_code: got %0d want 4", strobe_q[0]); end
            vectors++; if (strobe_t[0] != t + 1) begin miscompares++; $display("FAIL single_latency: got edge %0d want %0d", strobe_t[0], t + 1); end
        end
        vectors++; if (cmd !== 4'd4) begin miscompares++; $display("FAIL single_cmd_hold: got %0d want 4", cmd); end
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_low: got %b want 0", cmd_valid); end
        exp_cnt += 1;
        vectors++; if (issued_cnt !== CNT_W'(exp_cnt)) begin miscompares++; $display("FAIL single_cnt: got %0d want %0d", issued_cnt, exp_cnt); end
    endtask

    task automatic test_fifo_full();
        logic [3:0] model[$];
        logic [3:0] c;
        bit ok;
        int t, c0;
        busy = 1'b1;
        clear_log();
        for (int i = 0; i < DEPTH + 1; i++) begin
            c = 4'($urandom_range(1, 11));
            push_code(c, 1, ok, t);
            if (i < DEPTH) begin
                vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL full_push_%0d: accepted %b want 1", i, ok); end
                if (ok) model.push_back(c);
            end else begin
                vectors++; if (ok !== 1'b0) begin miscompares++; $display("FAIL full_overflow: accepted %b want 0", ok); end
            end
        end
        @(negedge clk);
        vectors++; if (push_ready !== 1'b0) begin miscompares++; $display("FAIL full_push_ready: got %b want 0", push_ready); end
        tick();
        busy = 1'b0;
        c0 = cyc;
        wait_cycles(DEPTH * GAP + 8);
        vectors++; if (strobe_q.size() != DEPTH) begin miscompares++; $display("FAIL full_drain_count: got %0d want %0d", strobe_q.size(), DEPTH); end
        for (int i = 0; i < model.size() && i < strobe_q.size(); i++) begin
            vectors++; if (strobe_q[i] !== model[i]) begin miscompares++; $display("FAIL full_order_%0d: got %0d want %0d", i, strobe_q[i], model[i]); end
            vectors++; if (strobe_t[i] != c0 + 1 + i * GAP) begin miscompares++; $display("FAIL full_time_%0d: got %0d want %0d", i, strobe_t[i], c0 + 1 + i * GAP); end
        end
        exp_cnt += DEPTH;
        vectors++; if (issued_cnt !== CNT_W'(exp_cnt)) begin miscompares++; $display("FAIL full_cnt: got %0d want %0d", issued_cnt, exp_cnt); end
    endtask

    task automatic test_illegal();
        logic [3:0] codes[3];
        bit ok;
        int t;
        codes[0] = 4'd2; codes[1] = 4'd13; codes[2] = 4'd3;
        vectors++; if (illegal_cmd !== 1'b0) begin miscompares++; $display("FAIL illegal_pre: got %b want 0", illegal_cmd); end
        busy = 1'b0;
        clear_log();
        for (int i = 0; i < 3; i++) begin
            push_code(codes[i], 2, ok, t);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL illegal_push_%0d: accepted %b want 1", i, ok); end
        end
        wait_cycles(16);
        vectors++; if (strobe_q.size() != 2) begin miscompares++; $display("FAIL illegal_count: got %0d want 2", strobe_q.size()); end
        if (strobe_q.size() == 2) begin
            vectors++; if (strobe_q[0] !== 4'd2) begin miscompares++; $display("FAIL illegal_first: got %0d want 2", strobe_q[0]); end
            vectors++; if (strobe_q[1] !== 4'd3) begin miscompares++; $display("FAIL illegal_second: got %0d want 3", strobe_q[1]); end
            // one extra idle cycle is spent discarding the illegal entry
            vectors++; if (strobe_t[1] - strobe_t[0] != GAP + 1) begin miscompares++; $display("FAIL illegal_spacing: got %0d want %0d", strobe_t[1] - strobe_t[0], GAP + 1); end
        end
        vectors++; if (illegal_cmd !== 1'b1) begin miscompares++; $display("FAIL illegal_flag: got %b want 1", illegal_cmd); end
        wait_cycles(10);
        vectors++; if (illegal_cmd !== 1'b1) begin miscompares++; $display("FAIL illegal_sticky: got %b want 1", illegal_cmd); end
        exp_cnt += 2;
        vectors++; if (issued_cnt !== CNT_W'(exp_cnt)) begin miscompares++; $display("FAIL illegal_cnt: got %0d want %0d", issued_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] model[$];
        logic [3:0] c;
        bit ok;
        int t;
        clear_log();
        done = 1'b1;   // done outside S_WAIT_DONE must have no effect
        for (int i = 0; i < 12; i++) begin
            c = 4'($urandom_range(1, 15));
            busy = 1'($urandom_range(0, 1));
            push_code(c, 4, ok, t);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rand_push_%0d: accepted %b want 1", i, ok); end
            if (ok && c < 4'd12) model.push_back(c);
        end
        busy = 1'b0;
        wait_cycles(12 * (GAP + 1) + 10);
        done = 1'b0;
        vectors++; if (strobe_q.size() != model.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", strobe_q.size(), model.size()); end
        for (int i = 0; i < model.size() && i < strobe_q.size(); i++) begin
            vectors++; if (strobe_q[i] !== model[i]) begin miscompares++; $display("FAIL rand_order_%0d: got %0d want %0d", i, strobe_q[i], model[i]); end
            if (i > 0) begin
                vectors++; if (strobe_t[i] - strobe_t[i-1] < GAP) begin miscompares++; $display("FAIL rand_spacing_%0d: got %0d want >=%0d", i, strobe_t[i] - strobe_t[i-1], GAP); end
            end
        end
        exp_cnt += model.size();
        vectors++; if (issued_cnt !== CNT_W'(exp_cnt)) begin miscompares++; $display("FAIL rand_cnt: got %0d want %0d", issued_cnt, exp_cnt); end
        vectors++; if (session_done !== 1'b0) begin miscompares++; $display("FAIL rand_stray_done: got %b want 0", session_done); end
    endtask

    task automatic test_session_end();
        bit ok;
        int t, s, n;
        busy = 1'b0;
        clear_log();
        push_code(4'd0, 2, ok, t);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL end_push_write: accepted %b want 1", ok); end
        push_code(4'd5, 2, ok, t);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL end_push_5: accepted %b want 1", ok); end
        n = 0;
        while (strobe_q.size() == 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (strobe_q.size() == 0) begin miscompares++; $display("FAIL end_write_strobe: got no strobe within 10 cycles, want one"); end
        if (strobe_q.size() > 0) begin
            vectors++; if (strobe_q[0] !== 4'd0) begin miscompares++; $display("FAIL end_write_code: got %0d want 0", strobe_q[0]); end
            s = strobe_t[0];
            n = 0;
            tick();
            while (cyc < s + 10 && n < 20) begin
                tick();
                n++;
            end
            vectors++; if (session_done !== 1'b0) begin miscompares++; $display("FAIL end_before_done: got %b want 0", session_done); end
            vectors++; if (push_ready !== 1'b1) begin miscompares++; $display("FAIL end_ready_before: got %b want 1", push_ready); end
            done = 1'b1;
            tick();
            done = 1'b0;
            vectors++; if (session_done !== 1'b1) begin miscompares++; $display("FAIL end_session_done: got %b want 1", session_done); end
            vectors++; if (push_ready !== 1'b0) begin miscompares++; $display("FAIL end_push_ready: got %b want 0", push_ready); end
        end
        wait_cycles(20);
        push_code(4'd7, 2, ok, t);
        vectors++; if (ok !== 1'b0) begin miscompares++; $display("FAIL end_push_after: accepted %b want 0", ok); end
        vectors++; if (strobe_q.size() != 1) begin miscompares++; $display("FAIL end_no_more: got %0d strobes want 1", strobe_q.size()); end
        vectors++; if (session_done !== 1'b1) begin miscompares++; $display("FAIL end_sticky: got %b want 1", session_done); end
        exp_cnt += 1;
        vectors++; if (issued_cnt !== CNT_W'(exp_cnt)) begin miscompares++; $display("FAIL end_cnt: got %0d want %0d", issued_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t, n;
        reset = 1'b0;
        repeat (2) tick();
        vectors++; if (session_done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_session: got %b want 0", session_done); end
        vectors++; if (illegal_cmd !== 1'b0) begin miscompares++; $display("FAIL mid_rst_illegal: got %b want 0", illegal_cmd); end
        vectors++; if (push_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 1", push_ready); end
        reset = 1'b1;
        exp_cnt = 0;
        busy = 1'b0;
        clear_log();
        push_code(4'd1, 2, ok, t);
        push_code(4'd7, 2, ok, t);
        n = 0;
        while (cmd_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL mid_strobe_seen: got %b want 1", cmd_valid); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", cmd_valid); end
        vectors++; if (cmd !== 4'd0) begin miscompares++; $display("FAIL mid_cmd: got %0d want 0", cmd); end
        vectors++; if (issued_cnt !== '0) begin miscompares++; $display("FAIL mid_cnt: got %0d want 0", issued_cnt); end
        tick();
        reset = 1'b1;
        clear_log();
        wait_cycles(10);
        vectors++; if (strobe_q.size() != 0) begin miscompares++; $display("FAIL mid_fifo_flushed: got %0d strobes want 0", strobe_q.size()); end
        push_code(4'd1, 2, ok, t);
        wait_cycles(8);
        vectors++; if (strobe_q.size() != 1) begin miscompares++; $display("FAIL mid_fresh_count: got %0d want 1", strobe_q.size()); end
        if (strobe_q.size() > 0) begin
            vectors++; if (strobe_q[0] !== 4'd1) begin miscompares++; $display("FAIL mid_fresh_code: got %0d want 1", strobe_q[0]); end
            vectors++; if (strobe_t[0] != t + 1) begin miscompares++; $display("FAIL mid_fresh_time: got %0d want %0d", strobe_t[0], t + 1); end
        end
        exp_cnt += 1;
        vectors++; if (issued_cnt !== CNT_W'(exp_cnt)) begin miscompares++; $display("FAIL mid_fresh_cnt: got %0d want %0d", issued_cnt, exp_cnt); end
    endtask

    initial begin
        reset      = 1'b0;
        push_valid = 1'b0;
        push_cmd   = 4'd0;
        busy       = 1'b0;
        done       = 1'b0;
        test_reset();
        test_busy_hold();
        test_single_latency();
        test_fifo_full();
        test_illegal();
        test_random();
        test_session_end();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
